// File: rtl/crc_pkg.sv
// Shared types and limits for the CRC frame serializer.
package crc_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    TAIL  = 2'd2
  } state_t;

  localparam int CRC_CNT_W      = 6;
  localparam int MAX_DATA_BYTES = 4;
  localparam int MAX_CRC_BITS   = 15;

endpackage

// File: rtl/crc_frame_serializer.sv
// Serializes a 1-4 byte frame onto DATA/ACTIVE, then holds off for the CRC tail.
// CRC_SER_MSB_FIRST_EN: send each byte MSB-first instead of LSB-first.
//
// state | meaning
// IDLE  | ready for a frame; IN_READY high
// SHIFT | frame bit on DATA, ACTIVE high
// TAIL  | downstream CRC generator owns the line; FRAME_DONE on last cycle
module crc_frame_serializer
  import crc_pkg::*;
#(
  parameter int DATA_BYTES = 1,
  parameter int CRC_BITS   = 8
) (
  input  logic                    CLK,
  input  logic                    RST,
  input  logic                    IN_VALID,
  input  logic [8*DATA_BYTES-1:0] IN_DATA,
  output logic                    IN_READY,
  output logic                    ACTIVE,
  output logic                    DATA,
  output logic                    FRAME_DONE
);

  localparam int N = 8 * DATA_BYTES;
  localparam logic [CRC_CNT_W-1:0] C_SHIFT_LAST = CRC_CNT_W'(N - 1);
  localparam logic [CRC_CNT_W-1:0] C_TAIL_LAST  = CRC_CNT_W'(CRC_BITS - 1);

  if (DATA_BYTES < 1 || DATA_BYTES > MAX_DATA_BYTES ||
      CRC_BITS < 1 || CRC_BITS > MAX_CRC_BITS) begin : g_bad_cfg
    $error("crc_frame_serializer: DATA_BYTES or CRC_BITS out of range");
  end

  state_t                 r_state;
  logic [N-1:0]           r_sr;
  logic [CRC_CNT_W-1:0]   r_cnt;
  logic                   r_active;
  logic                   r_data;
  logic                   r_done;
  logic [N-1:0]           w_ordered;

  // Reorder on load so the shifter itself always pops bit 0.
  always_comb begin
    w_ordered = IN_DATA;
`ifdef CRC_SER_MSB_FIRST_EN
    for (int b = 0; b < DATA_BYTES; b++) begin
      for (int j = 0; j < 8; j++) begin
        w_ordered[8*b+j] = IN_DATA[8*b+7-j];
      end
    end
`endif
  end

  assign IN_READY   = (r_state == IDLE) && !RST;
  assign ACTIVE     = r_active;
  assign DATA       = r_data;
  assign FRAME_DONE = r_done;

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state  <= IDLE;
      r_sr     <= '0;
      r_cnt    <= '0;
      r_active <= 1'b0;
      r_data   <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (IN_VALID && IN_READY) begin
            r_data   <= w_ordered[0];
            r_sr     <= w_ordered >> 1;
            r_active <= 1'b1;
            r_cnt    <= C_SHIFT_LAST;
            r_state  <= SHIFT;
          end
        end
        SHIFT: begin
          if (r_cnt == '0) begin
            r_active <= 1'b0;
            r_data   <= 1'b0;
            r_cnt    <= C_TAIL_LAST;
            // A one-cycle tail means its only cycle is also the last one.
            r_done   <= (CRC_BITS == 1);
            r_state  <= TAIL;
          end else begin
            r_data <= r_sr[0];
            r_sr   <= r_sr >> 1;
            r_cnt  <= r_cnt - 1'b1;
          end
        end
        TAIL: begin
          if (r_cnt == '0) begin
            r_state <= IDLE;
          end else begin
            r_cnt  <= r_cnt - 1'b1;
            r_done <= (r_cnt == CRC_CNT_W'(1));
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/crc_frame_serializer.md
# crc_frame_serializer

Upstream feeder for the serial CRC generator. It accepts a parallel frame of 1–4 bytes over a valid/ready handshake and shifts it out one bit per clock on `DATA`, holding `ACTIVE` high for the whole frame. It then holds off for `CRC_BITS` cycles while the CRC generator drives its CRC tail, and only then accepts the next frame. This guarantees that frames never overlap a CRC emission window.

## Interface
- `DATA_BYTES`, default 1: frame length in bytes, legal range 1..4.
- `CRC_BITS`, default 8: CRC width of the downstream generator and length of the hold-off tail in cycles, legal range 1..15.
- `CLK` input, 1 bit: the single clock; all logic on the rising edge.
- `RST` input, 1 bit: reset, synchronous, active-high.
- `IN_VALID` input, 1 bit: a frame is presented on `IN_DATA`.
- `IN_DATA` input, 8*DATA_BYTES bits: the frame; byte 0 is `IN_DATA[7:0]`.
- `IN_READY` output, 1 bit: the block can accept a frame this cycle.
- `ACTIVE` output, 1 bit: a frame bit is valid on `DATA`; connects to the generator's `ACTIVE`.
- `DATA` output, 1 bit: serial frame bit; connects to the generator's `DATA`.
- `FRAME_DONE` output, 1 bit: one-cycle pulse in the last tail cycle.

## Operation
- Three-state FSM with states `IDLE`, `SHIFT` and `TAIL`. The state register resets to `IDLE`.
- Internal registers are a shift register of `8*DATA_BYTES` bits and a 6-bit down-counter `cnt`.
- **IDLE**
  - `IN_READY` is 1 and is decoded from the registered state only.
  - When `IN_VALID & IN_READY`: load the shift register from `IN_DATA`, set `cnt = 8*DATA_BYTES-1`, and go to `SHIFT`.
- **SHIFT**
  - `ACTIVE` is 1. `DATA` is the current head bit. The head advances by one bit per cycle.
  - When `cnt == 0`: set `cnt = CRC_BITS-1` and go to `TAIL`. Otherwise `cnt` decrements.
- **TAIL**
  - `ACTIVE` is 0 and `DATA` is 0.
  - When `cnt == 0`: pulse `FRAME_DONE` and go to `IDLE`. Otherwise `cnt` decrements.
- Bit order is LSB-first by default: bit 0 of byte 0, then up to bit 7 of the last byte.
- `IN_READY` is 0 in `SHIFT` and in `TAIL`. `IN_VALID` asserted in those states is ignored, and `IN_DATA` is not sampled.
- `IN_DATA` is captured only on a handshake. Later changes to `IN_DATA` have no effect on the frame being shifted.
- `ACTIVE`, `DATA` and `FRAME_DONE` are registered outputs with no combinational path from inputs.
- `DATA` is 0 whenever `ACTIVE` is 0.
- Reset values: state = `IDLE`, `cnt = 0`, shift register = 0, `ACTIVE = 0`, `DATA = 0`, `FRAME_DONE = 0`.
- `IN_READY` is forced to 0 while `RST` is high.
- Reset mid-frame: the frame is aborted with no partial completion and no `FRAME_DONE`. `ACTIVE` drops in the cycle after the reset edge.

## Timing
- With the handshake at edge k and N = 8*DATA_BYTES:
  - `ACTIVE` is 1 for cycles k+1 .. k+N.
  - `DATA` in cycle k+i carries frame bit i-1.
  - Cycles k+N+1 .. k+N+CRC_BITS are the tail. `FRAME_DONE` is high in cycle k+N+CRC_BITS.
  - `IN_READY` rises in cycle k+N+CRC_BITS+1.
- Maximum throughput is one frame per N+CRC_BITS+1 cycles.
- Back-to-back: if `IN_VALID` is held high, the next frame is accepted in the first cycle `IN_READY` is 1. There is no extra bubble.
- Latency from handshake to the first serial bit is 1 cycle.

## Configuration
- Macro `CRC_SER_MSB_FIRST_EN`.
- Undefined: LSB-first order as described in Operation.
- Defined: each byte is sent MSB-first (bit 7 down to bit 0), with bytes still in order byte 0 to the last byte.
- Handshake, timing and tail length are identical in both cases.

## Structure
- Shared package `crc_pkg` holds:
  - the FSM state enum (`IDLE`, `SHIFT`, `TAIL`);
  - `CRC_CNT_W = 6`;
  - the legal-range limits `MAX_DATA_BYTES = 4` and `MAX_CRC_BITS = 15`.
- Single module with no sub-modules. The shift register, counter and FSM are small enough to be kept flat.

## Test plan
- **Single LSB-first byte:** `DATA_BYTES=1`, `CRC_BITS=8`, frame 0xA5 → `DATA` = 1,0,1,0,0,1,0,1 with `ACTIVE` high for 8 cycles, then 8 tail cycles with `ACTIVE=0`. `FRAME_DONE` pulses in cycle 16 after the handshake and `IN_READY` rises in cycle 17.
- **Two-byte frame:** `DATA_BYTES=2`, frame 0x1234 → 16 bits in the order 0x34 LSB-first then 0x12 LSB-first. `ACTIVE` is high for exactly 16 cycles.
- **Back-pressure:** hold `IN_VALID` high with 0x01 then 0xFF → the second frame is accepted exactly in the cycle `IN_READY` returns. The first frame's bits are unaffected by the `IN_DATA` change.
- **Reset mid-frame:** assert `RST` during the 4th bit → the next cycle shows `ACTIVE=0`, `DATA=0` and `FRAME_DONE=0`. After `RST` falls, `IN_READY=1`.
- **MSB-first build:** `CRC_SER_MSB_FIRST_EN` defined, frame 0x80 → `DATA` = 1 followed by seven 0s. Timing is identical to the first scenario.
- **End-to-end:** drive the CRC generator with random 1–4 byte frames and compare its CRC tail against the software model. No frame bit may overlap the generator's `Valid` window.
